smi_tx_packer: RTL

- Write-direction counterpart of the SMI read path. Receives bytes that the RPi writes over SMI and packs every 4 bytes into a 32-bit word.
- Pushes each completed word into the TX FIFO for the 0.9 GHz or 2.4 GHz channel. The channel is selected by the SMI address.
- Sits between the SMI pins and the two TX FIFOs. Also exposes status and control registers on the shared ioc register bus.

---
 rtl/smi_pkg.sv | 29 ++
 rtl/smi_sync_edge.sv | 30 +++
 rtl/smi_tx_packer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/smi_pkg.sv
// Shared definitions for the SMI TX packer: register indices, channel codes,
// FSM encoding and status bit positions.
package smi_pkg;

    localparam logic [4:0] IOC_MODULE_VERSION = 5'd0;
    localparam logic [4:0] IOC_FIFO_STATUS    = 5'd1;
    localparam logic [4:0] IOC_TX_CTRL        = 5'd2;
    localparam logic [4:0] IOC_TX_OVF_CNT     = 5'd3;

    localparam logic [2:0] SMI_CH_09 = 3'b000;
    localparam logic [2:0] SMI_CH_24 = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PUSH    = 2'd2
    } tx_state_e;

    localparam int STAT_FULL_09  = 0;
    localparam int STAT_FULL_24  = 1;
    localparam int STAT_OVF      = 2;
    localparam int STAT_CHAN_ERR = 3;
    localparam int STAT_BAD_ADDR = 4;
    localparam int STAT_TIMEOUT  = 5;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_FLUSH  = 1;

endpackage

// File: rtl/smi_sync_edge.sv
// Two-flop synchroniser for an asynchronous level with a one-cycle pulse on
// each synchronised rising edge.
module smi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_pulse
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_pulse = sync_q & ~prev_q;

endmodule

// File: rtl/smi_tx_packer.sv
// Packs SMI write bytes into 32-bit little-endian words for the 0.9/2.4 GHz TX FIFOs.
// Optional idle timeout for partial words: define SMI_TX_PARTIAL_TIMEOUT_EN.
module smi_tx_packer
    import smi_pkg::*;
#(
    parameter logic [7:0]  MODULE_VERSION = 8'h01,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        i_sys_clk,
    input  logic        i_rst_b,
    input  logic [4:0]  i_ioc,
    input  logic [7:0]  i_data_in,
    output logic [7:0]  o_data_out,
    input  logic        i_cs,
    input  logic        i_fetch_cmd,
    input  logic        i_load_cmd,
    input  logic [2:0]  i_smi_a,
    input  logic        i_smi_swe_srw,
    input  logic [7:0]  i_smi_data_in,
    output logic        o_smi_write_req,
    output logic        o_fifo_09_push,
    output logic [31:0] o_fifo_09_push_data,
    input  logic        i_fifo_09_full,
    output logic        o_fifo_24_push,
    output logic [31:0] o_fifo_24_push_data,
    input  logic        i_fifo_24_full
);

    // The strobe idles high, so its synchroniser resets high to avoid a false edge.
    logic byte_ev;

    smi_sync_edge #(.RESET_VAL(1'b1)) u_swe_sync (
        .clk        (i_sys_clk),
        .rst_n      (i_rst_b),
        .async_in   (i_smi_swe_srw),
        .rise_pulse (byte_ev)
    );

    logic [2:0] a_meta_q, a_sync_q;
    logic [7:0] d_meta_q, d_sync_q;

    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            a_meta_q <= '0;
            a_sync_q <= '0;
            d_meta_q <= '0;
            d_sync_q <= '0;
        end else begin
            a_meta_q <= i_smi_a;
            a_sync_q <= a_meta_q;
            d_meta_q <= i_smi_data_in;
            d_sync_q <= d_meta_q;
        end
    end

    tx_state_e   state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        chan_q, chan_d;
    logic        pend_q, pend_d;
    logic [7:0]  pend_data_q, pend_data_d;
    logic [2:0]  pend_addr_q, pend_addr_d;
    logic        enable_q, enable_d;
    logic        bad_q, bad_d;
    logic        chan_err_q, chan_err_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  ovf_cnt_q, ovf_cnt_d;
    logic        timeout_q, timeout_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic        push09_q, push09_d;
    logic        push24_q, push24_d;
    logic [31:0] data09_q, data09_d;
    logic [31:0] data24_q, data24_d;
    logic        wreq_q, wreq_d;
    logic [7:0]  dout_q, dout_d;

    logic        reg_wr;
    logic        flush;
    logic        ev;
    logic [7:0]  ev_data;
    logic [2:0]  ev_addr;
    logic        ev_chan;
    logic        sel_full;
    logic [7:0]  status;

    assign sel_full = chan_q ? i_fifo_24_full : i_fifo_09_full;
    assign status   = {2'b00, timeout_q, bad_q, chan_err_q, ovf_q, i_fifo_24_full, i_fifo_09_full};

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        cnt_d       = cnt_q;
        chan_d      = chan_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        pend_addr_d = pend_addr_q;
        enable_d    = enable_q;
        bad_d       = bad_q;
        chan_err_d  = chan_err_q;
        ovf_d       = ovf_q;
        ovf_cnt_d   = ovf_cnt_q;
        timeout_d   = timeout_q;
        idle_cnt_d  = idle_cnt_q;
        push09_d    = 1'b0;
        push24_d    = 1'b0;
        data09_d    = data09_q;
        data24_d    = data24_q;
        dout_d      = dout_q;
        ev          = 1'b0;
        ev_data     = d_sync_q;
        ev_addr     = a_sync_q;
        ev_chan     = 1'b0;

        reg_wr = i_cs && i_load_cmd;
        flush  = reg_wr && (i_ioc == IOC_TX_CTRL) && i_data_in[CTRL_FLUSH];
        if (reg_wr && (i_ioc == IOC_TX_CTRL))
            enable_d = i_data_in[CTRL_ENABLE];

        // A byte held over from a PUSH cycle is consumed before any new strobe.
        if (state_q == ST_IDLE && pend_q) begin
            ev          = 1'b1;
            ev_data     = pend_data_q;
            ev_addr     = pend_addr_q;
            pend_d      = byte_ev;
            pend_data_d = d_sync_q;
            pend_addr_d = a_sync_q;
        end else if (state_q == ST_PUSH) begin
            if (byte_ev) begin
                pend_d      = 1'b1;
                pend_data_d = d_sync_q;
                pend_addr_d = a_sync_q;
            end
        end else begin
            ev = byte_ev;
        end

        if (ev && enable_q) begin
            if (ev_addr != SMI_CH_09 && ev_addr != SMI_CH_24) begin
                bad_d = 1'b1;
            end else begin
                ev_chan = (ev_addr == SMI_CH_24);
                if (state_q == ST_IDLE || ev_chan != chan_q) begin
                    if (state_q == ST_COLLECT)
                        chan_err_d = 1'b1;
                    word_d  = {24'h0, ev_data};
                    cnt_d   = 2'd1;
                    chan_d  = ev_chan;
                    state_d = ST_COLLECT;
                end else begin
                    word_d[{cnt_q, 3'b000} +: 8] = ev_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3)
                        state_d = ST_PUSH;
                end
            end
        end

        if (state_q == ST_PUSH) begin
            if (sel_full) begin
                ovf_d = 1'b1;
                if (ovf_cnt_q != 8'hFF)
                    ovf_cnt_d = ovf_cnt_q + 8'd1;
            end else if (chan_q) begin
                push24_d = 1'b1;
                data24_d = word_q;
            end else begin
                push09_d = 1'b1;
                data09_d = word_q;
            end
            state_d = ST_IDLE;
            cnt_d   = 2'd0;
        end

`ifdef SMI_TX_PARTIAL_TIMEOUT_EN
        if (state_q != ST_COLLECT || ev) begin
            idle_cnt_d = 16'd0;
        end else if (idle_cnt_q + 16'd1 == TIMEOUT_CYCLES[15:0]) begin
            idle_cnt_d = 16'd0;
            timeout_d  = 1'b1;
            state_d    = ST_IDLE;
            cnt_d      = 2'd0;
            word_d     = 32'h0;
        end else begin
            idle_cnt_d = idle_cnt_q + 16'd1;
        end
`else
        idle_cnt_d = 16'd0;
        timeout_d  = 1'b0;
`endif

        // Flush overrides everything, including a byte arriving this cycle.
        if (flush) begin
            state_d    = ST_IDLE;
            word_d     = 32'h0;
            cnt_d      = 2'd0;
            pend_d     = 1'b0;
            bad_d      = 1'b0;
            chan_err_d = 1'b0;
            ovf_d      = 1'b0;
            ovf_cnt_d  = 8'd0;
            timeout_d  = 1'b0;
            idle_cnt_d = 16'd0;
            push09_d   = 1'b0;
            push24_d   = 1'b0;
            data09_d   = data09_q;
            data24_d   = data24_q;
        end

        wreq_d = enable_q && !sel_full;

        if (!i_cs) begin
            dout_d = 8'h00;
        end else if (i_fetch_cmd) begin
            case (i_ioc)
                IOC_MODULE_VERSION: dout_d = MODULE_VERSION;
                IOC_FIFO_STATUS:    dout_d = status;
                IOC_TX_CTRL:        dout_d = {7'b0, enable_q};
                IOC_TX_OVF_CNT:     dout_d = ovf_cnt_q;
                default:            dout_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state_q     <= ST_IDLE;
            word_q      <= '0;
            cnt_q       <= '0;
            chan_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            pend_addr_q <= '0;
            enable_q    <= 1'b0;
            bad_q       <= 1'b0;
            chan_err_q  <= 1'b0;
            ovf_q       <= 1'b0;
            ovf_cnt_q   <= '0;
            timeout_q   <= 1'b0;
            idle_cnt_q  <= '0;
            push09_q    <= 1'b0;
            push24_q    <= 1'b0;
            data09_q    <= '0;
            data24_q    <= '0;
            wreq_q      <= 1'b0;
            dout_q      <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            cnt_q       <= cnt_d;
            chan_q      <= chan_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            pend_addr_q <= pend_addr_d;
            enable_q    <= enable_d;
            bad_q       <= bad_d;
            chan_err_q  <= chan_err_d;
            ovf_q       <= ovf_d;
            ovf_cnt_q   <= ovf_cnt_d;
            timeout_q   <= timeout_d;
            idle_cnt_q  <= idle_cnt_d;
            push09_q    <= push09_d;
            push24_q    <= push24_d;
            data09_q    <= data09_d;
            data24_q    <= data24_d;
            wreq_q      <= wreq_d;
            dout_q      <= dout_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{i_data_in[7:2], TIMEOUT_CYCLES};

    assign o_data_out          = dout_q;
    assign o_smi_write_req     = wreq_q;
    assign o_fifo_09_push      = push09_q;
    assign o_fifo_09_push_data = data09_q;
    assign o_fifo_24_push      = push24_q;
    assign o_fifo_24_push_data = data24_q;

endmodule
